// File: rtl/bandpower.sv
`default_nettype none
// ============================================================================
//  Module      : bandpower
//  Description : Per-band mean-power meter for the 8-channel filter bank.
//                Snapshots eight signed 16-bit band samples per strobe,
//                squares them through one time-shared multiplier, accumulates
//                each band over 2^LOG2N samples and then streams the eight
//                window means out in band order, tagged with the band index.
//  Revision    : 1.0 - initial release
// ============================================================================
module bandpower #(
    parameter int LOG2N = 8                      // log2 of window length, 1..12
) (
    input  logic               clock,
    input  logic               reset,            // asynchronous, active-low
    input  logic               dout_enable,
    input  logic signed [15:0] dataout0,
    input  logic signed [15:0] dataout1,
    input  logic signed [15:0] dataout2,
    input  logic signed [15:0] dataout3,
    input  logic signed [15:0] dataout4,
    input  logic signed [15:0] dataout5,
    input  logic signed [15:0] dataout6,
    input  logic signed [15:0] dataout7,
    output logic        [30:0] power,
    output logic               power_valid,
    output logic        [2:0]  power_band,
    output logic               busy,
    output logic               overrun
);

    // Accumulator width: 31-bit squares summed 2^LOG2N times never overflow.
    localparam int c_ACC_W   = 31 + LOG2N;
    localparam int c_NBANDS  = 8;
    // Band counter value of the final SQR / DUMP cycle.
    localparam logic [3:0] c_K_LAST = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SQR  = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    state_t                r_state;
    logic [15:0]           r_snap [c_NBANDS];
    logic [c_ACC_W-1:0]    r_acc  [c_NBANDS];
    logic [LOG2N-1:0]      r_sample;
    // Band counter shared by SQR (0..8) and DUMP (1..8).
    logic [3:0]            r_k;
    // Registered square of the band selected on the previous SQR cycle.
    logic [30:0]           r_prod;

    logic [15:0]           w_din [c_NBANDS];
    logic [15:0]           w_sel;
    logic [15:0]           w_mag;
    logic [30:0]           w_sq;
    logic [2:0]            w_acc_idx;
    logic [c_ACC_W-1:0]    w_acc_sum;
    logic [30:0]           w_dump_val;
    logic                  w_window_done;
    logic                  w_strobe_busy;

    assign w_din[0] = dataout0;
    assign w_din[1] = dataout1;
    assign w_din[2] = dataout2;
    assign w_din[3] = dataout3;
    assign w_din[4] = dataout4;
    assign w_din[5] = dataout5;
    assign w_din[6] = dataout6;
    assign w_din[7] = dataout7;

    // Datapath: squarer on the selected snapshot, accumulate and dump taps.
    always_comb begin
        w_sel         = r_snap[r_k[2:0]];
        // Square via magnitude: |-32768| = 32768 still fits 16 unsigned bits,
        // and the 31-bit product holds the worst case 2^30 exactly.
        w_mag         = w_sel[15] ? (~w_sel + 16'd1) : w_sel;
        w_sq          = 31'(w_mag) * 31'(w_mag);
        // Accumulation lags the multiply by one cycle; at k=8 this wraps to 7.
        w_acc_idx     = r_k[2:0] - 3'd1;
        w_acc_sum     = r_acc[w_acc_idx] + {{LOG2N{1'b0}}, r_prod};
        // Mean is a plain truncating shift by LOG2N.
        w_dump_val    = r_acc[r_k[2:0]][LOG2N+30:LOG2N];
        w_window_done = (r_sample == {LOG2N{1'b1}});
        w_strobe_busy = dout_enable && (r_state != ST_IDLE);
    end

    // Control FSM with registered outputs, snapshot and accumulator state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_sample    <= '0;
            r_k         <= '0;
            r_prod      <= '0;
            power       <= '0;
            power_valid <= 1'b0;
            power_band  <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < c_NBANDS; i++) begin
                r_snap[i] <= '0;
                r_acc[i]  <= '0;
            end
        end else begin
            power_valid <= 1'b0;

            // Strobes that land while processing are dropped but flagged.
            if (w_strobe_busy) begin
                overrun <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (dout_enable) begin
                        for (int i = 0; i < c_NBANDS; i++) begin
                            r_snap[i] <= w_din[i];
                        end
                        r_k     <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_SQR;
                    end
                end

                ST_SQR: begin
                    // k=0..7 multiplies band k; k=1..8 folds band k-1 in.
                    if (r_k != c_K_LAST) begin
                        r_prod <= w_sq;
                    end
                    if (r_k != 4'd0) begin
                        r_acc[w_acc_idx] <= w_acc_sum;
                    end

                    if (r_k == c_K_LAST) begin
                        if (w_window_done) begin
                            // Band 0 is already final, so it leaves on this
                            // edge and appears in the first DUMP cycle.
                            r_sample    <= '0;
                            power       <= w_dump_val;
                            power_valid <= 1'b1;
                            power_band  <= 3'd0;
                            r_acc[0]    <= '0;
                            r_k         <= 4'd1;
                            r_state     <= ST_DUMP;
                        end else begin
                            r_sample    <= r_sample + LOG2N'(1);
                            r_k         <= '0;
                            busy        <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end

                ST_DUMP: begin
                    if (r_k == c_K_LAST) begin
                        // Band 7 is on the outputs this cycle; close out.
                        r_k     <= '0;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        power              <= w_dump_val;
                        power_valid        <= 1'b1;
                        power_band         <= r_k[2:0];
                        r_acc[r_k[2:0]]    <= '0;
                        r_k                <= r_k + 4'd1;
                    end
                end

                default: begin
                    r_k     <= '0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/bandpower.md
# bandpower

Per-band mean-power meter sitting directly downstream of the 8-channel filter bank (`profir`). It snapshots the eight 16-bit band outputs on each output strobe and squares them with a single time-shared multiplier. It accumulates each band over a window of 2^LOG2N samples, then streams the eight window means out sequentially, tagged with the band index. It feeds the level-display and AGC logic.

## Interface
- `LOG2N`, 8: log2 of window length in samples; legal range 1..12.
- `clock` in 1: master 250 MHz clock, rising edge.
- `reset` in 1: master reset, asynchronous, active-low.
- `dout_enable` in 1: one-cycle strobe; `dataout0..7` hold a new valid sample set this cycle.
- `dataout0`..`dataout7` in 16 each, signed: filter bank band outputs 0..7.
- `power` out 31, unsigned: mean power of band `power_band` for the completed window.
- `power_valid` out 1: `power`/`power_band` valid this cycle.
- `power_band` out 3: band index of `power`.
- `busy` out 1: block is processing and will not accept a strobe.
- `overrun` out 1: sticky; a strobe arrived while `busy`.

## Operation
- FSM states: IDLE, SQR, DUMP.
- IDLE: on `dout_enable`=1, register all eight inputs into snapshot regs and go to SQR. Otherwise hold.
- SQR: 9 cycles. Band counter k=0..7 selects snapshot k into the multiplier.
  - Product is registered as p_k = x_k*x_k, 31 bits unsigned; max (-32768)^2 = 2^30.
  - Next cycle, acc[k] += p_k. acc[k] is 31+LOG2N bits wide and cannot overflow.
- End of SQR:
  - If sample counter == 2^LOG2N-1: go to DUMP and set the sample counter to 0.
  - Else: increment the sample counter and go to IDLE.
- DUMP: 8 cycles, band k=0..7 in order.
  - `power` = acc[k][LOG2N+30:LOG2N], i.e. truncating divide, no rounding.
  - `power_valid`=1, `power_band`=k.
  - acc[k] is cleared in the same cycle it is output.
  - Then go to IDLE.
- `busy`=1 in SQR and DUMP.
- A `dout_enable` while `busy`=1 is ignored: no snapshot, no counter change, accumulators untouched. `overrun` is set to 1 and stays 1 until reset.
- Accumulators are only ever read or cleared in DUMP; there is no partial-window output.

## Timing
- Strobe at cycle t (IDLE), snapshot captured at the t edge.
- `busy` is 1 from t+1 through t+9 (SQR).
- If the window completes:
  - `busy` stays 1 through t+17.
  - `power_valid`=1 for bands 0..7 at cycles t+10..t+17.
  - `busy` returns to 0 at t+18.
- Minimum accepted strobe spacing: 10 cycles for non-final samples, 18 cycles for the final sample of a window. The filter bank's 64-cycle sample period satisfies both.
- A strobe in the first IDLE cycle (t+10 or t+18) is accepted.
- Reset values, applied immediately on `reset`=0 regardless of state:
  - `power`=0, `power_valid`=0, `power_band`=0, `busy`=0, `overrun`=0.
  - All accumulators, snapshots and the sample counter are 0; FSM returns to IDLE.
- Reset during SQR or DUMP aborts the window; no remaining outputs are emitted.
- Outside DUMP: `power_valid`=0, while `power` and `power_band` hold their last values.

## Test plan
(All scenarios use LOG2N=2, strobes every 64 cycles unless noted.)
- All bands = 1000 for 4 strobes -> after the 4th strobe (t), `power`=1000000 with `power_band`=0..7 at t+10..t+17; no `power_valid` after strobes 1–3.
- Band k = -32768 for all k, 4 strobes -> `power`=1073741824 on all 8 bands; no wrap.
- Distinct per-band values, band k = 100*(k+1), 4 strobes -> outputs 10000, 40000, 90000, …, 640000 in band order 0..7.
- Band 0 sequence 1,1,1,0 -> `power`=0 (3/4 truncated). Band 1 sequence 100,0,100,0 -> 5000.
- Second strobe at t+5 -> ignored, `overrun`=1 and held. Window results equal those with the extra strobe absent.
- `reset` pulsed low at t+12 of a dump -> all outputs 0 immediately, no further `power_valid`. Next 4-strobe window of value 10 yields 100 per band, with no residue from the aborted window.
